booth_product_accumulator: RTL
==============================

BOOTH_PRODUCT_ACCUMULATOR -- requirements
Module: booth_product_accumulator

Interface
REQ-001 SHALL have parameter STEPS, default 32, meaning radix-4 Booth steps per 64-bit multiply.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, level request to begin a multiply; sampled only in IDLE and DONE.
REQ-005 SHALL have port shiftedMultiplicand, input, 128, the pre-aligned signed partial product from the multiplier/multiplicand controller.
REQ-006 SHALL have port op, output, 2, current state driven to the controller: 00 IDLE, 01 CALCULATING, 10 DONE.
REQ-007 SHALL have port product, output, 128, signed accumulated product.
REQ-008 SHALL have port busy, output, 1, high exactly while op is CALCULATING.
REQ-009 SHALL have port done, output, 1, high exactly while op is DONE.

Function
REQ-010 SHALL implement a three-state machine with states IDLE, CALCULATING and DONE; op is the registered state, and 11 is never produced.
REQ-011 In IDLE with start=1, SHALL move to CALCULATING at the next edge, clear product to 0 and clear the step counter to 0; the controller loads its operands at that same edge.
REQ-012 In IDLE with start=0, SHALL remain in IDLE and hold product.
REQ-013 In each CALCULATING cycle, SHALL update product <= (product >>> 2) + shiftedMultiplicand, with the shift arithmetic (sign-replicating) and the add as 128-bit two's complement that discards the carry-out.
REQ-014 SHALL count CALCULATING cycles; after exactly STEPS updates it SHALL move to DONE, giving op=01 for exactly STEPS consecutive cycles.
REQ-015 SHALL ignore start while in CALCULATING.
REQ-016 SHALL hold product constant in DONE.
REQ-017 In DONE, SHALL move to IDLE at the first edge where start=0; while start stays 1 it SHALL remain in DONE, so one start level yields one multiply.
REQ-018 Total latency from the start-sampling edge to done=1 SHALL be STEPS+1 edges, i.e. 33 for the default.
REQ-019 product SHALL equal the exact signed 128-bit product of the 64-bit operands loaded at start, including the case where both operands are the most negative value.
REQ-020 busy, done and op SHALL be mutually consistent in every cycle, and SHALL be decoded from the state register with no combinational path from start.

Reset
REQ-021 When reset=1 at an edge, the block SHALL set state to IDLE, op=00, product=0, the step counter to 0, busy=0 and done=0, overriding start.
REQ-022 A reset in mid-CALCULATING SHALL abort the multiply with no residual state; the next start SHALL give a correct product.

Structure
REQ-023 A shared package SHALL hold the state encodings (IDLE=00, CALCULATING=01, DONE=10) and the default STEPS, for use by both this block and the multiplier/multiplicand controller.
REQ-024 The step counter SHALL be one sub-module, booth_step_counter, with inputs clear and enable and output last.
REQ-025 The accumulator register and its shift-add SHALL be inline in this block, with no further hierarchy.

Verification
REQ-026 With the controller in the bench, multiplier=3 and multiplicand=5, pulse start: done rises 33 edges later and product=15.
REQ-027 Operands -1 and 1: product = 128'hFFFF...FFFF, i.e. -1.
REQ-028 Both operands 64'h8000_0000_0000_0000: product = 128'h4000_0000_0000_0000_0000_0000_0000_0000.
REQ-029 Assert reset on the 10th CALCULATING cycle: next cycle op=00 and product=0; then run 7×(-9) to completion and check product=-63.
REQ-030 Hold start high through DONE for 5 cycles: op stays 10 and product holds; drop start and op=00 next edge; start during CALCULATING has no effect.

Source files
------------

// File: rtl/booth_product_accumulator_pkg.sv
// Shared definitions for the Booth product accumulator and its operand controller.
// State encodings are visible on the op port, so both sides must agree on them.
package booth_product_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        CALCULATING = 2'b01,
        DONE        = 2'b10
    } boothState_t;

    localparam int DEFAULT_STEPS = 32;
    localparam int PRODUCT_WIDTH = 128;

    // Room for every count value 0..steps.
    function automatic int stepCountWidth(input int steps);
        return (steps < 1) ? 1 : $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/booth_step_counter.sv
// Counts accumulation steps of one multiply; last flags the final step.
// The count parks on the final value until the next clear.
module booth_step_counter
    import booth_product_accumulator_pkg::*;
#(
    parameter int STEPS = DEFAULT_STEPS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CW = stepCountWidth(STEPS);

    logic [CW-1:0] stepCount;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            stepCount <= '0;
        end else if (enable && !last) begin
            stepCount <= stepCount + CW'(1);
        end
    end

    assign last = (stepCount == CW'(STEPS - 1));

endmodule

// File: rtl/booth_product_accumulator.sv
// Radix-4 Booth accumulator: shifts the running product right by one digit and
// adds the controller's pre-aligned partial product, once per step.
//
// state       | meaning
// IDLE        | waiting for start; product holds the last result
// CALCULATING | one shift-add per cycle, STEPS cycles
// DONE        | result valid and held until start drops
module booth_product_accumulator
    import booth_product_accumulator_pkg::*;
#(
    parameter int STEPS = DEFAULT_STEPS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [PRODUCT_WIDTH-1:0] shiftedMultiplicand,
    output logic [1:0]               op,
    output logic [PRODUCT_WIDTH-1:0] product,
    output logic                     busy,
    output logic                     done
);

    boothState_t state;
    boothState_t nextState;
    logic        clearSteps;
    logic        stepLast;

    // Kept as a separate signed net so the shift stays arithmetic regardless of
    // the signedness of the addend.
    logic signed [PRODUCT_WIDTH-1:0] productShifted;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState  = state;
        clearSteps = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState  = CALCULATING;
                    clearSteps = 1'b1;
                end
            end
            CALCULATING: begin
                if (stepLast) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    booth_step_counter #(
        .STEPS(STEPS)
    ) stepCounter (
        .clk   (clk),
        .reset (reset),
        .clear (clearSteps),
        .enable(state == CALCULATING),
        .last  (stepLast)
    );

    assign productShifted = $signed(product) >>> 2;

    always_ff @(posedge clk) begin
        if (reset) begin
            product <= '0;
        end else if (state == IDLE && start) begin
            product <= '0;
        end else if (state == CALCULATING) begin
            product <= productShifted + shiftedMultiplicand;
        end
    end

    assign op   = state;
    assign busy = (state == CALCULATING);
    assign done = (state == DONE);

endmodule
